// File: rtl/axi_mem_req_master_pkg.sv
// Shared types and constants for the SRAM-request to AXI4 single-beat master bridge.
package axi_mem_req_master_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    case (resp)
      RESP_SLVERR, RESP_DECERR: err = 1'b1;
      RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
      default:                  err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/axi_mem_req_master.sv
// Converts a req/gnt/rvalid memory port into single-beat AXI4 transactions, one outstanding.
// Optional error reporting on err_o is enabled by defining AXI_MEM_REQ_MASTER_ERR_EN.
module axi_mem_req_master
  import axi_mem_req_master_pkg::*;
#(
  parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI4_DATA_WIDTH    = 64,
  parameter int unsigned AXI4_ID_WIDTH      = 16,
  parameter int unsigned AXI4_USER_WIDTH    = 10,
  parameter int unsigned AXI_NUMBYTES       = AXI4_DATA_WIDTH / 8,
  parameter int unsigned MEM_ADDR_WIDTH     = 13,
  parameter logic [AXI4_ADDRESS_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned AXI_ID             = 0
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,

  input  logic                          req_i,
  input  logic                          we_i,
  input  logic [MEM_ADDR_WIDTH-1:0]     addr_i,
  input  logic [AXI4_DATA_WIDTH-1:0]    wdata_i,
  input  logic [AXI_NUMBYTES-1:0]       be_i,
  output logic                          gnt_o,
  output logic                          rvalid_o,
  output logic [AXI4_DATA_WIDTH-1:0]    rdata_o,
  output logic                          err_o,

  output logic [AXI4_ID_WIDTH-1:0]      AWID_o,
  output logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR_o,
  output logic [7:0]                    AWLEN_o,
  output logic [2:0]                    AWSIZE_o,
  output logic [1:0]                    AWBURST_o,
  output logic                          AWLOCK_o,
  output logic [3:0]                    AWCACHE_o,
  output logic [2:0]                    AWPROT_o,
  output logic [3:0]                    AWREGION_o,
  output logic [AXI4_USER_WIDTH-1:0]    AWUSER_o,
  output logic [3:0]                    AWQOS_o,
  output logic                          AWVALID_o,
  input  logic                          AWREADY_i,

  output logic [AXI4_DATA_WIDTH-1:0]    WDATA_o,
  output logic [AXI_NUMBYTES-1:0]       WSTRB_o,
  output logic                          WLAST_o,
  output logic [AXI4_USER_WIDTH-1:0]    WUSER_o,
  output logic                          WVALID_o,
  input  logic                          WREADY_i,

  input  logic [AXI4_ID_WIDTH-1:0]      BID_i,
  input  logic [1:0]                    BRESP_i,
  input  logic [AXI4_USER_WIDTH-1:0]    BUSER_i,
  input  logic                          BVALID_i,
  output logic                          BREADY_o,

  output logic [AXI4_ID_WIDTH-1:0]      ARID_o,
  output logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR_o,
  output logic [7:0]                    ARLEN_o,
  output logic [2:0]                    ARSIZE_o,
  output logic [1:0]                    ARBURST_o,
  output logic                          ARLOCK_o,
  output logic [3:0]                    ARCACHE_o,
  output logic [2:0]                    ARPROT_o,
  output logic [3:0]                    ARREGION_o,
  output logic [AXI4_USER_WIDTH-1:0]    ARUSER_o,
  output logic [3:0]                    ARQOS_o,
  output logic                          ARVALID_o,
  input  logic                          ARREADY_i,

  input  logic [AXI4_ID_WIDTH-1:0]      RID_i,
  input  logic [AXI4_DATA_WIDTH-1:0]    RDATA_i,
  input  logic [1:0]                    RRESP_i,
  input  logic                          RLAST_i,
  input  logic [AXI4_USER_WIDTH-1:0]    RUSER_i,
  input  logic                          RVALID_i,
  output logic                          RREADY_o
);

  localparam int OFFSET_BIT = $clog2(AXI4_DATA_WIDTH) - 3;
  localparam logic [2:0] AX_SIZE = 3'($clog2(AXI_NUMBYTES));

  state_t state_q, state_d;

  logic                          awvalid_q, awvalid_d;
  logic                          wvalid_q, wvalid_d;
  logic                          arvalid_q, arvalid_d;
  logic                          bready_q, bready_d;
  logic                          rready_q, rready_d;
  logic                          rvalid_q, rvalid_d;
  logic                          aw_done_q, aw_done_d;
  logic                          w_done_q, w_done_d;
  logic                          latch_req;
  logic                          capture_b;
  logic                          capture_r;
  logic                          gnt;

  logic [AXI4_ADDRESS_WIDTH-1:0] addr_q;
  logic [AXI4_DATA_WIDTH-1:0]    wdata_q;
  logic [AXI_NUMBYTES-1:0]       be_q;
  logic [AXI4_DATA_WIDTH-1:0]    rdata_q;
  logic [AXI4_ADDRESS_WIDTH-1:0] axi_addr;

  // Word address scaled to a byte address of one full data beat.
  assign axi_addr = BASE_ADDR + (AXI4_ADDRESS_WIDTH'(addr_i) << OFFSET_BIT);

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    rvalid_d  = 1'b0;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    latch_req = 1'b0;
    capture_b = 1'b0;
    capture_r = 1'b0;
    gnt       = 1'b0;

    case (state_q)
      IDLE: begin
        gnt = req_i;
        if (req_i) begin
          latch_req = 1'b1;
          if (we_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        if (awvalid_q && AWREADY_i) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && WREADY_i) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // AW and W complete independently; move on once both have landed.
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (BVALID_i) begin
          bready_d  = 1'b0;
          rvalid_d  = 1'b1;
          capture_b = 1'b1;
          state_d   = IDLE;
        end
      end

      RD_REQ: begin
        if (ARREADY_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (RVALID_i) begin
          rready_d  = 1'b0;
          rvalid_d  = 1'b1;
          capture_r = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      rvalid_q  <= rvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (latch_req) begin
        addr_q <= axi_addr;
      end
      if (latch_req && we_i) begin
        wdata_q <= wdata_i;
        be_q    <= be_i;
      end
      if (capture_r) begin
        rdata_q <= RDATA_i;
      end
    end
  end

`ifdef AXI_MEM_REQ_MASTER_ERR_EN
  logic err_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (capture_b && resp_is_err(BRESP_i)) || (capture_r && resp_is_err(RRESP_i));
    end
  end

  assign err_o = err_q;

  logic unused_inputs;
  assign unused_inputs = ^{BID_i, BUSER_i, RID_i, RLAST_i, RUSER_i};
`else
  assign err_o = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{BID_i, BUSER_i, RID_i, RLAST_i, RUSER_i, BRESP_i, RRESP_i};
`endif

  assign gnt_o    = gnt;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

  // Single-beat INCR bursts with all side-band attributes at their neutral values.
  assign AWID_o     = AXI4_ID_WIDTH'(AXI_ID);
  assign AWADDR_o   = addr_q;
  assign AWLEN_o    = 8'd0;
  assign AWSIZE_o   = AX_SIZE;
  assign AWBURST_o  = BURST_INCR;
  assign AWLOCK_o   = 1'b0;
  assign AWCACHE_o  = 4'd0;
  assign AWPROT_o   = 3'd0;
  assign AWREGION_o = 4'd0;
  assign AWUSER_o   = '0;
  assign AWQOS_o    = 4'd0;
  assign AWVALID_o  = awvalid_q;

  assign WDATA_o    = wdata_q;
  assign WSTRB_o    = be_q;
  assign WLAST_o    = 1'b1;
  assign WUSER_o    = '0;
  assign WVALID_o   = wvalid_q;

  assign BREADY_o   = bready_q;

  assign ARID_o     = AXI4_ID_WIDTH'(AXI_ID);
  assign ARADDR_o   = addr_q;
  assign ARLEN_o    = 8'd0;
  assign ARSIZE_o   = AX_SIZE;
  assign ARBURST_o  = BURST_INCR;
  assign ARLOCK_o   = 1'b0;
  assign ARCACHE_o  = 4'd0;
  assign ARPROT_o   = 3'd0;
  assign ARREGION_o = 4'd0;
  assign ARUSER_o   = '0;
  assign ARQOS_o    = 4'd0;
  assign ARVALID_o  = arvalid_q;

  assign RREADY_o   = rready_q;

endmodule

// File: tb/tb_axi_mem_req_master.sv
// Directed, table-driven bench for axi_mem_req_master with hand-written multi-cycle sequences.
// Expects err_o only when AXI_MEM_REQ_MASTER_ERR_EN is defined for the build.
module tb_axi_mem_req_master;
  import axi_mem_req_master_pkg::*;

`ifdef AXI_MEM_REQ_MASTER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        ACLK;
  logic        ARESETn;
  logic        req_i, we_i;
  logic [12:0] addr_i;
  logic [63:0] wdata_i;
  logic [7:0]  be_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [63:0] rdata_o;

  logic [15:0] AWID_o, ARID_o, BID_i, RID_i;
  logic [31:0] AWADDR_o, ARADDR_o;
  logic [7:0]  AWLEN_o, ARLEN_o;
  logic [2:0]  AWSIZE_o, ARSIZE_o, AWPROT_o, ARPROT_o;
  logic [1:0]  AWBURST_o, ARBURST_o, BRESP_i, RRESP_i;
  logic        AWLOCK_o, ARLOCK_o;
  logic [3:0]  AWCACHE_o, ARCACHE_o, AWREGION_o, ARREGION_o, AWQOS_o, ARQOS_o;
  logic [9:0]  AWUSER_o, ARUSER_o, WUSER_o, BUSER_i, RUSER_i;
  logic        AWVALID_o, AWREADY_i, WVALID_o, WREADY_i, WLAST_o;
  logic [63:0] WDATA_o, RDATA_i;
  logic [7:0]  WSTRB_o;
  logic        BVALID_i, BREADY_o, ARVALID_o, ARREADY_i, RLAST_i, RVALID_i, RREADY_o;

  int checks;
  int failures;

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [1:0]  resp;
    logic [63:0] rdata;
    logic [31:0] exp_addr;
    logic        err_if_enabled;
  } vec_t;

  vec_t vecs[7];

  axi_mem_req_master #(
    .BASE_ADDR(32'h1000_0000)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .AWID_o(AWID_o), .AWADDR_o(AWADDR_o), .AWLEN_o(AWLEN_o), .AWSIZE_o(AWSIZE_o),
    .AWBURST_o(AWBURST_o), .AWLOCK_o(AWLOCK_o), .AWCACHE_o(AWCACHE_o), .AWPROT_o(AWPROT_o),
    .AWREGION_o(AWREGION_o), .AWUSER_o(AWUSER_o), .AWQOS_o(AWQOS_o), .AWVALID_o(AWVALID_o),
    .AWREADY_i(AWREADY_i),
    .WDATA_o(WDATA_o), .WSTRB_o(WSTRB_o), .WLAST_o(WLAST_o), .WUSER_o(WUSER_o),
    .WVALID_o(WVALID_o), .WREADY_i(WREADY_i),
    .BID_i(BID_i), .BRESP_i(BRESP_i), .BUSER_i(BUSER_i), .BVALID_i(BVALID_i), .BREADY_o(BREADY_o),
    .ARID_o(ARID_o), .ARADDR_o(ARADDR_o), .ARLEN_o(ARLEN_o), .ARSIZE_o(ARSIZE_o),
    .ARBURST_o(ARBURST_o), .ARLOCK_o(ARLOCK_o), .ARCACHE_o(ARCACHE_o), .ARPROT_o(ARPROT_o),
    .ARREGION_o(ARREGION_o), .ARUSER_o(ARUSER_o), .ARQOS_o(ARQOS_o), .ARVALID_o(ARVALID_o),
    .ARREADY_i(ARREADY_i),
    .RID_i(RID_i), .RDATA_i(RDATA_i), .RRESP_i(RRESP_i), .RLAST_i(RLAST_i), .RUSER_i(RUSER_i),
    .RVALID_i(RVALID_i), .RREADY_o(RREADY_o)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic cycleStep();
    @(posedge ACLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Zero-wait slave: request at T, AxVALID at T+1, response at T+2, rvalid_o at T+3.
  task automatic applyStimulus(input vec_t v, input int idx);
    req_i = 1'b1; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata; be_i = v.be;
    AWREADY_i = 1'b1; WREADY_i = 1'b1; ARREADY_i = 1'b1;
    #1;
    checkOutput($sformatf("v%0d_gnt", idx), 64'(gnt_o), 64'd1);
    cycleStep();
    req_i = 1'b0;
    if (v.we) begin
      checkOutput($sformatf("v%0d_awvalid", idx), 64'(AWVALID_o), 64'd1);
      checkOutput($sformatf("v%0d_wvalid", idx), 64'(WVALID_o), 64'd1);
      checkOutput($sformatf("v%0d_awaddr", idx), 64'(AWADDR_o), 64'(v.exp_addr));
      checkOutput($sformatf("v%0d_wdata", idx), WDATA_o, v.wdata);
      checkOutput($sformatf("v%0d_wstrb", idx), 64'(WSTRB_o), 64'(v.be));
      checkOutput($sformatf("v%0d_awattr", idx), {AWLEN_o, 5'd0, AWSIZE_o, 6'd0, AWBURST_o, 7'd0, WLAST_o},
                  {8'd0, 5'd0, 3'd3, 6'd0, 2'b01, 7'd0, 1'b1});
    end else begin
      checkOutput($sformatf("v%0d_arvalid", idx), 64'(ARVALID_o), 64'd1);
      checkOutput($sformatf("v%0d_araddr", idx), 64'(ARADDR_o), 64'(v.exp_addr));
      checkOutput($sformatf("v%0d_arattr", idx), {ARLEN_o, 5'd0, ARSIZE_o, 6'd0, ARBURST_o},
                  {8'd0, 5'd0, 3'd3, 6'd0, 2'b01});
    end
    cycleStep();
    checkOutput($sformatf("v%0d_valids_low", idx), {AWVALID_o, WVALID_o, ARVALID_o}, 64'd0);
    checkOutput($sformatf("v%0d_ready", idx), {BREADY_o, RREADY_o}, v.we ? 64'b10 : 64'b01);
    checkOutput($sformatf("v%0d_rvalid_early", idx), 64'(rvalid_o), 64'd0);
    if (v.we) begin
      BVALID_i = 1'b1; BRESP_i = v.resp;
    end else begin
      RVALID_i = 1'b1; RDATA_i = v.rdata; RRESP_i = v.resp;
    end
    cycleStep();
    BVALID_i = 1'b0; RVALID_i = 1'b0; RDATA_i = '0;
    checkOutput($sformatf("v%0d_rvalid", idx), 64'(rvalid_o), 64'd1);
    checkOutput($sformatf("v%0d_err", idx), 64'(err_o), 64'(ERR_EN & v.err_if_enabled));
    if (!v.we) begin
      checkOutput($sformatf("v%0d_rdata", idx), rdata_o, v.rdata);
    end
    cycleStep();
    checkOutput($sformatf("v%0d_rvalid_pulse", idx), 64'(rvalid_o), 64'd0);
    checkOutput($sformatf("v%0d_ready_idle", idx), {BREADY_o, RREADY_o}, 64'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    ARESETn = 1'b0;
    req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; be_i = '0;
    AWREADY_i = 0; WREADY_i = 0; ARREADY_i = 0;
    BID_i = '0; BRESP_i = '0; BUSER_i = '0; BVALID_i = 0;
    RID_i = '0; RDATA_i = '0; RRESP_i = '0; RLAST_i = 1'b1; RUSER_i = '0; RVALID_i = 0;

    vecs[0] = '{we:1'b0, addr:13'h010,  wdata:64'h0, be:8'h00, resp:RESP_OKAY,
                rdata:64'hDEAD_BEEF_0123_4567, exp_addr:32'h1000_0080, err_if_enabled:1'b0};
    vecs[1] = '{we:1'b1, addr:13'h1FFF, wdata:64'h0123_4567_89AB_CDEF, be:8'hFF, resp:RESP_OKAY,
                rdata:64'h0, exp_addr:32'h1000_FFF8, err_if_enabled:1'b0};
    vecs[2] = '{we:1'b0, addr:13'h000,  wdata:64'h0, be:8'h00, resp:RESP_SLVERR,
                rdata:64'hFFFF_FFFF_FFFF_FFFF, exp_addr:32'h1000_0000, err_if_enabled:1'b1};
    vecs[3] = '{we:1'b1, addr:13'h0AB,  wdata:64'hA5A5_A5A5_5A5A_5A5A, be:8'h0F, resp:RESP_SLVERR,
                rdata:64'h0, exp_addr:32'h1000_0558, err_if_enabled:1'b1};
    vecs[4] = '{we:1'b0, addr:13'h1234, wdata:64'h0, be:8'h00, resp:RESP_DECERR,
                rdata:64'h0, exp_addr:32'h1000_91A0, err_if_enabled:1'b1};
    vecs[5] = '{we:1'b1, addr:13'h0001, wdata:64'hFEED_0000_0000_BEEF, be:8'h80, resp:RESP_EXOKAY,
                rdata:64'h0, exp_addr:32'h1000_0008, err_if_enabled:1'b0};
    vecs[6] = '{we:1'b0, addr:13'h0FFF, wdata:64'h0, be:8'h00, resp:RESP_EXOKAY,
                rdata:64'h1122_3344_5566_7788, exp_addr:32'h1000_7FF8, err_if_enabled:1'b0};

    cycleStep();
    cycleStep();
    ARESETn = 1'b1;
    cycleStep();
    checkOutput("reset_valids", {AWVALID_o, WVALID_o, ARVALID_o, BREADY_o, RREADY_o}, 64'd0);
    checkOutput("reset_resp", {rvalid_o, err_o}, 64'd0);
    checkOutput("reset_rdata", rdata_o, 64'd0);
    checkOutput("reset_addr", 64'(AWADDR_o), 64'd0);
    checkOutput("reset_wdata", WDATA_o, 64'd0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], i);
    end

    // W accepted before AW: WREADY at T+1, AWREADY at T+4, BVALID at T+6.
    req_i = 1'b1; we_i = 1'b1; addr_i = 13'h005; wdata_i = 64'h0BAD_F00D_CAFE_0001; be_i = 8'h0F;
    AWREADY_i = 1'b0; WREADY_i = 1'b0;
    #1;
    checkOutput("wfirst_gnt", 64'(gnt_o), 64'd1);
    cycleStep();
    req_i = 1'b0;
    checkOutput("wfirst_t1_valid", {AWVALID_o, WVALID_o}, 64'b11);
    checkOutput("wfirst_wstrb", 64'(WSTRB_o), 64'h0F);
    checkOutput("wfirst_awaddr", 64'(AWADDR_o), 64'h1000_0028);
    WREADY_i = 1'b1;
    cycleStep();
    WREADY_i = 1'b0;
    checkOutput("wfirst_t2_valid", {AWVALID_o, WVALID_o}, 64'b10);
    cycleStep();
    checkOutput("wfirst_t3_valid", {AWVALID_o, WVALID_o, BREADY_o}, 64'b100);
    cycleStep();
    checkOutput("wfirst_t4_valid", {AWVALID_o, WVALID_o, BREADY_o}, 64'b100);
    AWREADY_i = 1'b1;
    cycleStep();
    AWREADY_i = 1'b0;
    checkOutput("wfirst_t5_state", {AWVALID_o, WVALID_o, BREADY_o, rvalid_o}, 64'b0010);
    cycleStep();
    checkOutput("wfirst_t6_bready", 64'(BREADY_o), 64'd1);
    BVALID_i = 1'b1; BRESP_i = RESP_OKAY;
    cycleStep();
    BVALID_i = 1'b0;
    checkOutput("wfirst_t7_rvalid", {rvalid_o, BREADY_o}, 64'b10);
    cycleStep();

    // Requester holds req_i while a read waits 10 cycles for RVALID.
    req_i = 1'b1; we_i = 1'b0; addr_i = 13'h020; ARREADY_i = 1'b1;
    #1;
    checkOutput("bp_gnt_t0", 64'(gnt_o), 64'd1);
    cycleStep();
    addr_i = 13'h021;
    checkOutput("bp_gnt_t1", 64'(gnt_o), 64'd0);
    checkOutput("bp_araddr", 64'(ARADDR_o), 64'h1000_0100);
    cycleStep();
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("bp_wait%0d", i), {gnt_o, RREADY_o, rvalid_o}, 64'b010);
      cycleStep();
    end
    RVALID_i = 1'b1; RDATA_i = 64'hCAFE_F00D_1234_5678; RRESP_i = RESP_OKAY;
    checkOutput("bp_gnt_t12", 64'(gnt_o), 64'd0);
    cycleStep();
    RVALID_i = 1'b0;
    checkOutput("bp_rvalid", 64'(rvalid_o), 64'd1);
    checkOutput("bp_rdata", rdata_o, 64'hCAFE_F00D_1234_5678);
    checkOutput("bp_regrant", 64'(gnt_o), 64'd1);
    cycleStep();
    req_i = 1'b0;
    checkOutput("bp_next_ar", {ARVALID_o, rvalid_o}, 64'b10);
    checkOutput("bp_next_araddr", 64'(ARADDR_o), 64'h1000_0108);
    cycleStep();
    RVALID_i = 1'b1; RDATA_i = 64'h55;
    cycleStep();
    RVALID_i = 1'b0;
    checkOutput("bp_next_rvalid", 64'(rvalid_o), 64'd1);
    checkOutput("bp_next_rdata", rdata_o, 64'h55);
    cycleStep();

    // Reset asserted while AWVALID/WVALID are pending.
    req_i = 1'b1; we_i = 1'b1; addr_i = 13'h002; wdata_i = 64'h1; be_i = 8'hFF;
    AWREADY_i = 1'b0; WREADY_i = 1'b0;
    cycleStep();
    req_i = 1'b0;
    checkOutput("rst_pre_valid", {AWVALID_o, WVALID_o}, 64'b11);
    ARESETn = 1'b0;
    #1;
    checkOutput("rst_valids", {AWVALID_o, WVALID_o, BREADY_o, rvalid_o}, 64'd0);
    checkOutput("rst_addr", 64'(AWADDR_o), 64'd0);
    cycleStep();
    cycleStep();
    ARESETn = 1'b1;
    cycleStep();
    checkOutput("rst_post", {AWVALID_o, WVALID_o, BREADY_o, rvalid_o}, 64'd0);
    AWREADY_i = 1'b1; WREADY_i = 1'b1;
    cycleStep();
    checkOutput("rst_no_resp", 64'(rvalid_o), 64'd0);
    applyStimulus(vecs[6], 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
